// File: rtl/imm_sequencer.sv
// Immediate-operand sequencer: forms the ALU B operand from decoded immediates
// into a one-entry output register. Prefix merging is built only with IMM_PREFIX_EN.
module imm_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  output logic        inReady,
  input  logic [7:0]  immediate,
  input  logic [2:0]  immClass,
  input  logic [15:0] regOperand,
  output logic        outValid,
  input  logic        outReady,
  output logic [15:0] extImm,
  output logic        signExtImm,
  output logic        prefixPending,
  output logic        prefixErr,
  output logic        illegal
);

  localparam logic [2:0] CLS_REG    = 3'd0;
  localparam logic [2:0] CLS_SIMM   = 3'd1;
  localparam logic [2:0] CLS_UIMM   = 3'd2;
  localparam logic [2:0] CLS_LUI    = 3'd3;
  localparam logic [2:0] CLS_PREFIX = 3'd4;
  localparam logic [2:0] CLS_SHIFT  = 3'd5;

  logic        out_valid_q, out_valid_d;
  logic [15:0] ext_imm_q, ext_imm_d;
  logic        sign_ext_q, sign_ext_d;
  logic        prefix_err_q, prefix_err_d;
  logic        illegal_q, illegal_d;

  logic        accept;
  logic        is_reserved;
  logic [15:0] formed_ext;
  logic        formed_sign;

`ifdef IMM_PREFIX_EN
  typedef enum logic {IDLE, PREFIXED} state_e;
  state_e      state_q, state_d;
  logic [7:0]  upper_byte_q, upper_byte_d;
`endif

  // A held entry stalls every request, prefixes included.
  assign inReady = !out_valid_q || outReady;
  assign accept  = inValid && inReady;

`ifdef IMM_PREFIX_EN
  assign is_reserved = immClass[2] && immClass[1];
`else
  assign is_reserved = immClass[2] && (immClass[1] || !immClass[0]);
`endif

  // Operand as formed with no prefix in effect.
  always_comb begin
    formed_ext  = regOperand;
    formed_sign = 1'b0;
    case (immClass)
      CLS_REG:   formed_ext = regOperand;
      CLS_SIMM: begin
        formed_ext  = {{8{immediate[7]}}, immediate};
        formed_sign = 1'b1;
      end
      CLS_UIMM:  formed_ext = {8'h00, immediate};
      CLS_LUI:   formed_ext = {immediate, 8'h00};
      CLS_SHIFT: formed_ext = {12'h000, immediate[3:0]};
      default:   formed_ext = regOperand;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q && !outReady;
    ext_imm_d    = ext_imm_q;
    sign_ext_d   = sign_ext_q;
    prefix_err_d = 1'b0;
    illegal_d    = 1'b0;
`ifdef IMM_PREFIX_EN
    state_d      = state_q;
    upper_byte_d = upper_byte_q;
    if (accept) begin
      if (immClass == CLS_PREFIX) begin
        upper_byte_d = immediate;
        state_d      = PREFIXED;
        prefix_err_d = (state_q == PREFIXED);
      end else begin
        out_valid_d = 1'b1;
        ext_imm_d   = formed_ext;
        sign_ext_d  = formed_sign;
        illegal_d   = is_reserved;
        state_d     = IDLE;
        if (state_q == PREFIXED) begin
          // Only plain immediates can take the captured upper byte.
          if (immClass == CLS_SIMM || immClass == CLS_UIMM) begin
            ext_imm_d  = {upper_byte_q, immediate};
            sign_ext_d = 1'b0;
          end else begin
            prefix_err_d = 1'b1;
          end
        end
      end
    end
`else
    if (accept) begin
      out_valid_d = 1'b1;
      ext_imm_d   = formed_ext;
      sign_ext_d  = formed_sign;
      illegal_d   = is_reserved;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      ext_imm_q    <= 16'h0000;
      sign_ext_q   <= 1'b0;
      prefix_err_q <= 1'b0;
      illegal_q    <= 1'b0;
`ifdef IMM_PREFIX_EN
      state_q      <= IDLE;
      upper_byte_q <= 8'h00;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      ext_imm_q    <= ext_imm_d;
      sign_ext_q   <= sign_ext_d;
      prefix_err_q <= prefix_err_d;
      illegal_q    <= illegal_d;
`ifdef IMM_PREFIX_EN
      state_q      <= state_d;
      upper_byte_q <= upper_byte_d;
`endif
    end
  end

  assign outValid   = out_valid_q;
  assign extImm     = ext_imm_q;
  assign signExtImm = sign_ext_q;
  assign illegal    = illegal_q;
`ifdef IMM_PREFIX_EN
  assign prefixPending = (state_q == PREFIXED);
  assign prefixErr     = prefix_err_q;
`else
  assign prefixPending = 1'b0;
  assign prefixErr     = 1'b0;
`endif

endmodule

// File: tb/tb_imm_sequencer.sv
// Randomized bench for imm_sequencer against a behavioural operand model;
// follows IMM_PREFIX_EN to match the build of the design.
module tb_imm_sequencer;

`ifdef IMM_PREFIX_EN
  localparam bit PFX = 1'b1;
`else
  localparam bit PFX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [7:0]  immediate = 8'h00;
  logic [2:0]  immClass = 3'd0;
  logic [15:0] regOperand = 16'h0000;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [15:0] extImm;
  logic        signExtImm;
  logic        prefixPending;
  logic        prefixErr;
  logic        illegal;

  imm_sequencer dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .immediate(immediate), .immClass(immClass), .regOperand(regOperand),
    .outValid(outValid), .outReady(outReady), .extImm(extImm),
    .signExtImm(signExtImm), .prefixPending(prefixPending),
    .prefixErr(prefixErr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model state: what the ALU should see, and the prefix context.
  bit        m_valid, m_sign, m_pend, m_perr, m_ill;
  bit [15:0] m_ext;
  bit [7:0]  m_upper;

  function automatic bit [16:0] form(input bit [2:0] c, input bit [7:0] i, input bit [15:0] r);
    bit [15:0] v;
    bit        s;
    s = 1'b0;
    case (c)
      3'd1: begin v = 16'($signed(i)); s = 1'b1; end
      3'd2: v = 16'(i);
      3'd3: v = 16'(i) * 16'd256;
      3'd5: v = 16'(i % 8'd16);
      default: v = r;
    endcase
    return {s, v};
  endfunction

  task automatic model_step(input bit v, input bit [2:0] c, input bit [7:0] i,
                            input bit [15:0] r, input bit ordy, input bit rst);
    bit        acc;
    bit [16:0] f;
    if (rst) begin
      m_valid = 0; m_ext = 0; m_sign = 0; m_pend = 0; m_perr = 0; m_ill = 0; m_upper = 0;
      return;
    end
    acc = v && (!m_valid || ordy);
    m_perr = 0;
    m_ill  = 0;
    if (!acc) begin
      if (ordy) m_valid = 0;
    end else if (PFX && c == 3'd4) begin
      m_perr  = m_pend;
      m_pend  = 1;
      m_upper = i;
      if (ordy) m_valid = 0;
    end else begin
      if (m_pend && (c == 3'd1 || c == 3'd2)) begin
        m_ext  = {m_upper, i};
        m_sign = 0;
      end else begin
        m_perr = m_pend;
        f = form(c, i, r);
        m_sign = f[16];
        m_ext  = f[15:0];
      end
      m_pend  = 0;
      m_valid = 1;
      m_ill   = (c >= 3'd6) || (!PFX && c == 3'd4);
    end
  endtask

  task automatic cycle(input bit v, input bit [2:0] c, input bit [7:0] i,
                       input bit [15:0] r, input bit ordy, input bit rst);
    @(negedge clk);
    inValid = v; immClass = c; immediate = i; regOperand = r; outReady = ordy; reset = rst;
    #1;
    if (!rst) chk("inReady", inReady, !m_valid || ordy);
    model_step(v, c, i, r, ordy, rst);
    @(posedge clk);
    #1;
    chk("outValid", outValid, m_valid);
    chk("extImm", extImm, m_ext);
    chk("signExtImm", signExtImm, m_sign);
    chk("prefixPending", prefixPending, m_pend);
    chk("prefixErr", prefixErr, m_perr);
    chk("illegal", illegal, m_ill);
  endtask

  initial begin
    cycle(0, 0, 0, 0, 1, 1);
    cycle(1, 3'd1, 8'h55, 16'h0, 1, 1);
    chk("rst_outValid", outValid, 0);
    chk("rst_extImm", extImm, 16'h0000);

    cycle(1, 3'd1, 8'h80, 16'h0, 1, 0);
    chk("simm_ext", extImm, 16'hFF80);
    chk("simm_sign", signExtImm, 1);

    cycle(1, 3'd2, 8'h80, 16'h0, 1, 0);
    chk("uimm_ext", extImm, 16'h0080);
    cycle(1, 3'd3, 8'h12, 16'h0, 1, 0);
    chk("lui_ext", extImm, 16'h1200);
    chk("lui_valid", outValid, 1);

    if (PFX) begin
      cycle(1, 3'd4, 8'hAB, 16'h0, 1, 0);
      chk("pfx_pending", prefixPending, 1);
      chk("pfx_noout", outValid, 0);
      cycle(1, 3'd2, 8'hCD, 16'h0, 1, 0);
      chk("merge_ext", extImm, 16'hABCD);
      cycle(1, 3'd4, 8'h11, 16'h0, 1, 0);
      cycle(1, 3'd5, 8'hF7, 16'h0, 1, 0);
      chk("perr_pulse", prefixErr, 1);
      chk("perr_ext", extImm, 16'h0007);
      cycle(0, 3'd0, 8'h00, 16'h0, 1, 0);
      chk("perr_clear", prefixErr, 0);
    end else begin
      cycle(1, 3'd4, 8'hAB, 16'h1234, 1, 0);
      chk("cls4_ext", extImm, 16'h1234);
      chk("cls4_ill", illegal, 1);
      cycle(0, 3'd0, 8'h00, 16'h0, 1, 0);
      chk("ill_clear", illegal, 0);
    end

    // Stall: hold an entry, then present a request while outReady is low.
    cycle(1, 3'd2, 8'h3C, 16'h0, 0, 0);
    cycle(1, 3'd1, 8'h01, 16'h0, 0, 0);
    chk("stall_ext", extImm, 16'h003C);
    cycle(1, 3'd1, 8'h01, 16'h0, 1, 0);
    chk("unstall_ext", extImm, 16'h0001);

    // Reset while a prefix is captured and an entry is held.
    cycle(1, 3'd4, 8'h77, 16'h0, 0, 0);
    cycle(0, 3'd0, 8'h00, 16'h0, 0, 1);
    chk("rstmid_pend", prefixPending, 0);
    chk("rstmid_valid", outValid, 0);
    cycle(1, 3'd2, 8'h05, 16'h0, 1, 0);
    chk("rstmid_ext", extImm, 16'h0005);

    for (int n = 0; n < 400; n++) begin
      bit [2:0] c;
      c = (($urandom % 4) == 0) ? 3'd4 : 3'($urandom % 8);
      cycle(($urandom % 4) != 0, c, 8'($urandom), 16'($urandom),
            ($urandom % 10) < 7, ($urandom % 50) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
